ralu_sequencer: RTL and testbench
=================================

Name: ralu_sequencer

Overview:
- Command-level controller that drives every control input of the RALU (register file plus ALU datapath), so software or the future instruction decoder no longer hand-sequences S/M/v/adr/wr words each cycle.
- Accepts one command at a time over a valid/ready handshake and expands it into a fixed multi-cycle micro-step sequence.
- Reports completion together with a captured status bit (carry or shifted-out bit).
- Sits between the central-unit decoder and the RALU instance.

Parameters:
- DATA_W, 4, RALU data width (DataIn, immediate).
- ADR_W, 3, GPRB address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command (IDLE only).
- cmd_op  in  3  opcode: 0 LDI, 1 ADD, 2 AND, 3 SHL, 4-7 illegal.
- cmd_src_a  in  ADR_W  first source GPRB address.
- cmd_src_b  in  ADR_W  second source GPRB address.
- cmd_dst  in  ADR_W  destination GPRB address.
- cmd_imm  in  DATA_W  LDI immediate; for SHL, bits[1:0] give shift count minus 1.
- cmd_fill  in  1  shift-in bit for SHL.
- abort  in  1  synchronous abort of the command in flight.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse when an illegal opcode is accepted.
- busy  out  1  high in every state except IDLE.
- status  out  1  captured Pout (ADD/AND) or OSL (SHL); held until the next done.
- DataIn, S, M, Pin, ISR, ISL, A, wr, adr, v  out  RALU widths (DATA_W, 4, 1, 1, 1, 1, 1, 1, ADR_W, 4)  RALU control word.
- Pout, OSL, OSR  in  1 each  RALU status outputs (OSR reserved, unused).

Behaviour:
- Reset (async): state IDLE; all control outputs 0 (the NOP word); done=err=busy=status=0; cmd_ready=1.
- All outputs are registered. The control word for a step is driven for exactly one cycle, and the RALU samples it at the following edge.
- Accept: cmd_valid & cmd_ready at an edge. All cmd_* fields are latched at that edge and ignored afterwards. The first step word appears in the next cycle.
- Step sequences (unlisted fields stay 0):
  - LDI: IMM {A=1, v=0001, DataIn=imm} -> WRITE {wr=1, adr=dst} -> DONE.
  - ADD: LOADA {adr=src_a, v=0001} -> LOADB {adr=src_b, v=0110} -> EXEC {S=1001, M=1, wr=1, adr=dst} -> DONE.
  - AND: same as ADD except EXEC {S=0100, M=0}.
  - SHL: LOADB {adr=src_a, v=0110} -> SHIFT x N {S=0101, v=0010, ISL=ISR=fill}, with N=imm[1:0]+1 (1..4). The last SHIFT step also has wr=1, adr=dst. Then DONE.
- Shift counter: 2-bit down-counter loaded with imm[1:0] on accept. It decrements once per SHIFT step; the step in which the counter is 0 is the last one. There is no wrap.
- status:
  - ADD/AND: Pout sampled at the end of the EXEC cycle.
  - SHL: OSL sampled at the end of the last SHIFT cycle.
  - LDI: status cleared to 0.
  - status is updated on the same edge that enters DONE.
- DONE: one cycle; done=1, NOP word, cmd_ready=0. Returns to IDLE, so the next accept is possible one cycle later.
- Latency from accept to done: LDI 3, ADD/AND 4, SHL 2+N cycles.
- Illegal opcode: on accept, go to ERR for one cycle (err=1, NOP word, no done), then IDLE. status is unchanged.
- abort: sampled in any non-IDLE state; takes priority over the step transition.
  - Next state is IDLE with the NOP word; no done, no err.
  - Writes already committed in earlier steps are not undone.
  - abort in IDLE has no effect; abort together with an accept in IDLE accepts the command.
- Reset mid-operation: immediate NOP word and IDLE, independent of the clock.
- cmd_valid held while busy: the command waits because cmd_ready=0; no loss and no duplicate accept.

Decomposition:
- Package ralu_seq_pkg holds:
  - opcode constants OP_LDI, OP_ADD, OP_AND, OP_SHL;
  - S encodings S_ADD=1001, S_AND=0100, S_SHL=0101;
  - v encodings V_LDA=0001, V_LDB=0110, V_SHB=0010;
  - the state enum IDLE, IMM, LOADA, LOADB, EXEC, SHIFT, WRITE, DONE, ERR.
- One sub-module, ralu_ctrl_decode: combinational next-state to control-word mapping, whose result the top registers. The FSM, counter and status capture stay in the top.

Test Plan:
- After reset: cmd_ready=1, all control outputs 0. LDI imm=3 dst=0 -> IMM word {A=1, v=0001, DataIn=3}, then WRITE {wr=1, adr=0}; done pulses 3 cycles after accept; a RALU model holds GPRB[0]=3.
- LDI 12 -> GPRB[1], then ADD src_a=0 src_b=1 dst=1 -> LOADA, LOADB, EXEC {S=1001, M=1, wr=1, adr=1}; GPRB[1]=15 (3+12), status=Pout=0, done 4 cycles after accept.
- SHL src_a=0 dst=0 imm[1:0]=2 fill=0 with GPRB[0]=3 -> exactly 3 SHIFT cycles, wr only on the third; GPRB[0]=8 (0011<<3, truncated), status=OSL of the final shift=1; done 5 cycles after accept.
- cmd_op=5 -> err pulse 1 cycle after accept, no done, no RALU write, status unchanged. A second cmd_valid held high during a busy ADD is accepted only after DONE->IDLE.
- abort asserted in LOADB of an ADD -> next cycle IDLE, NOP word, no done, GPRB[dst] unchanged. Async reset asserted mid-SHIFT -> outputs 0 immediately, counter cleared, cmd_ready=1 after release.

Source files
------------

// File: rtl/ralu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ralu_seq_pkg
//  Purpose  : Shared opcodes, RALU control encodings and the sequencer state
//             type used by ralu_sequencer and ralu_ctrl_decode.
//  Revision : 1.0  initial release
// ============================================================================
package ralu_seq_pkg;

  // Command opcodes (4..7 are illegal)
  localparam logic [2:0] OP_LDI = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;

  // ALU function select (S)
  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_AND = 4'b0100;
  localparam logic [3:0] S_SHL = 4'b0101;

  // Register load enables (v)
  localparam logic [3:0] V_LDA = 4'b0001;
  localparam logic [3:0] V_LDB = 4'b0110;
  localparam logic [3:0] V_SHB = 4'b0010;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    IMM   = 4'd1,
    LOADA = 4'd2,
    LOADB = 4'd3,
    EXEC  = 4'd4,
    SHIFT = 4'd5,
    WRITE = 4'd6,
    DONE  = 4'd7,
    ERR   = 4'd8
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ralu_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module   : ralu_ctrl_decode
//  Purpose  : Combinational mapping from the sequencer's next state and the
//             command fields to the RALU control word for that step. The
//             result is registered by the parent so every output is a flop.
//  Ports    : nxt_state        state the sequencer enters at the next edge
//             op/src_a/src_b/dst/imm/fill  effective command fields
//             last_shift       next SHIFT step is the final one
//             data_in..v       RALU control word for the next step
//  Revision : 1.0  initial release
// ============================================================================
module ralu_ctrl_decode
  import ralu_seq_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADR_W  = 3
) (
  input  state_e             nxt_state,
  input  logic [2:0]         op,
  input  logic [ADR_W-1:0]   src_a,
  input  logic [ADR_W-1:0]   src_b,
  input  logic [ADR_W-1:0]   dst,
  input  logic [DATA_W-1:0]  imm,
  input  logic               fill,
  input  logic               last_shift,
  output logic [DATA_W-1:0]  data_in,
  output logic [3:0]         s,
  output logic               m,
  output logic               pin,
  output logic               isr,
  output logic               isl,
  output logic               a,
  output logic               wr,
  output logic [ADR_W-1:0]   adr,
  output logic [3:0]         v
);

  always_comb begin
    data_in = '0;
    s       = 4'b0000;
    m       = 1'b0;
    pin     = 1'b0;
    isr     = 1'b0;
    isl     = 1'b0;
    a       = 1'b0;
    wr      = 1'b0;
    adr     = '0;
    v       = 4'b0000;
    case (nxt_state)
      IMM: begin
        a       = 1'b1;
        v       = V_LDA;
        data_in = imm;
      end
      WRITE: begin
        wr  = 1'b1;
        adr = dst;
      end
      LOADA: begin
        adr = src_a;
        v   = V_LDA;
      end
      LOADB: begin
        // SHL shifts its single operand through the B path
        adr = (op == OP_SHL) ? src_a : src_b;
        v   = V_LDB;
      end
      EXEC: begin
        s   = (op == OP_AND) ? S_AND : S_ADD;
        m   = (op == OP_ADD);
        wr  = 1'b1;
        adr = dst;
      end
      SHIFT: begin
        s   = S_SHL;
        v   = V_SHB;
        isl = fill;
        isr = fill;
        if (last_shift) begin
          wr  = 1'b1;
          adr = dst;
        end
      end
      default: ;  // IDLE, DONE, ERR drive the NOP word
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ralu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ralu_sequencer
//  Purpose  : Accepts one RALU command (LDI/ADD/AND/SHL) over valid/ready and
//             expands it into a fixed sequence of registered RALU control
//             words, then pulses done with a captured status bit.
//  Ports    : clock, reset (async, active high)
//             cmd_valid/cmd_ready/cmd_*   command handshake and fields
//             abort                       cancel the command in flight
//             done/err/busy/status        completion and state reporting
//             DataIn,S,M,Pin,ISR,ISL,A,wr,adr,v   RALU control word
//             Pout, OSL, OSR              RALU status inputs (OSR unused)
//  Revision : 1.0  initial release
// ============================================================================
module ralu_sequencer
  import ralu_seq_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADR_W  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [ADR_W-1:0]   cmd_src_a,
  input  logic [ADR_W-1:0]   cmd_src_b,
  input  logic [ADR_W-1:0]   cmd_dst,
  input  logic [DATA_W-1:0]  cmd_imm,
  input  logic               cmd_fill,
  input  logic               abort,
  output logic               done,
  output logic               err,
  output logic               busy,
  output logic               status,
  output logic [DATA_W-1:0]  DataIn,
  output logic [3:0]         S,
  output logic               M,
  output logic               Pin,
  output logic               ISR,
  output logic               ISL,
  output logic               A,
  output logic               wr,
  output logic [ADR_W-1:0]   adr,
  output logic [3:0]         v,
  input  logic               Pout,
  input  logic               OSL,
  input  logic               OSR
);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADR_W-1:0]    src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                fill_q, fill_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                status_q, status_d;
  logic                done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                accept, last_shift;

  logic [DATA_W-1:0]   data_in_q, data_in_d;
  logic [3:0]          s_q, s_d, v_q, v_d;
  logic                m_q, m_d, pin_q, pin_d, isr_q, isr_d, isl_q, isl_d;
  logic                a_q, a_d, wr_q, wr_d;
  logic [ADR_W-1:0]    adr_q, adr_d;

  logic                unused_osr;
  assign unused_osr = OSR;

  always_comb begin
    accept   = (state_q == IDLE) && cmd_valid;
    state_d  = state_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    // Fields are taken straight from the port on the accept edge so the
    // first step word can be decoded in the same cycle.
    op_d     = accept ? cmd_op    : op_q;
    src_a_d  = accept ? cmd_src_a : src_a_q;
    src_b_d  = accept ? cmd_src_b : src_b_q;
    dst_d    = accept ? cmd_dst   : dst_q;
    imm_d    = accept ? cmd_imm   : imm_q;
    fill_d   = accept ? cmd_fill  : fill_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = cmd_imm[1:0];
          case (cmd_op)
            OP_LDI:         state_d = IMM;
            OP_ADD, OP_AND: state_d = LOADA;
            OP_SHL:         state_d = LOADB;
            default:        state_d = ERR;
          endcase
        end
      end
      IMM:   state_d = WRITE;
      WRITE: begin
        state_d  = DONE;
        status_d = 1'b0;
      end
      LOADA: state_d = LOADB;
      LOADB: state_d = (op_q == OP_SHL) ? SHIFT : EXEC;
      EXEC: begin
        state_d  = DONE;
        status_d = Pout;
      end
      SHIFT: begin
        // Counter value 0 marks the final shift; it never wraps.
        if (cnt_q == 2'd0) begin
          state_d  = DONE;
          status_d = OSL;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides the step transition; status is left untouched.
    if ((state_q != IDLE) && abort) begin
      state_d  = IDLE;
      status_d = status_q;
      cnt_d    = cnt_q;
    end

    last_shift = (state_d == SHIFT) && (cnt_d == 2'd0);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
    busy_d     = (state_d != IDLE);
    ready_d    = (state_d == IDLE);
  end

  ralu_ctrl_decode #(
    .DATA_W (DATA_W),
    .ADR_W  (ADR_W)
  ) u_decode (
    .nxt_state  (state_d),
    .op         (op_d),
    .src_a      (src_a_d),
    .src_b      (src_b_d),
    .dst        (dst_d),
    .imm        (imm_d),
    .fill       (fill_d),
    .last_shift (last_shift),
    .data_in    (data_in_d),
    .s          (s_d),
    .m          (m_d),
    .pin        (pin_d),
    .isr        (isr_d),
    .isl        (isl_d),
    .a          (a_d),
    .wr         (wr_d),
    .adr        (adr_d),
    .v          (v_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      imm_q     <= '0;
      fill_q    <= 1'b0;
      cnt_q     <= 2'd0;
      status_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      data_in_q <= '0;
      s_q       <= 4'b0000;
      m_q       <= 1'b0;
      pin_q     <= 1'b0;
      isr_q     <= 1'b0;
      isl_q     <= 1'b0;
      a_q       <= 1'b0;
      wr_q      <= 1'b0;
      adr_q     <= '0;
      v_q       <= 4'b0000;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      dst_q     <= dst_d;
      imm_q     <= imm_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      data_in_q <= data_in_d;
      s_q       <= s_d;
      m_q       <= m_d;
      pin_q     <= pin_d;
      isr_q     <= isr_d;
      isl_q     <= isl_d;
      a_q       <= a_d;
      wr_q      <= wr_d;
      adr_q     <= adr_d;
      v_q       <= v_d;
    end
  end

  assign cmd_ready = ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign status    = status_q;
  assign DataIn    = data_in_q;
  assign S         = s_q;
  assign M         = m_q;
  assign Pin       = pin_q;
  assign ISR       = isr_q;
  assign ISL       = isl_q;
  assign A         = a_q;
  assign wr        = wr_q;
  assign adr       = adr_q;
  assign v         = v_q;

endmodule
`default_nettype wire

// File: tb/tb_ralu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ralu_sequencer
//  Purpose  : Scoreboard bench for ralu_sequencer with a small behavioural
//             RALU (GPRB, A/B registers, ALU) driven by the control word.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ralu_sequencer;
  import ralu_seq_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = 3'd0, cmd_src_a = 3'd0, cmd_src_b = 3'd0, cmd_dst = 3'd0;
  logic [3:0] cmd_imm = 4'd0;
  logic       cmd_fill = 1'b0, abort = 1'b0;
  logic       done, err, busy, status;
  logic [3:0] DataIn, S, v;
  logic       M, Pin, ISR, ISL, A, wr;
  logic [2:0] adr;
  logic       Pout, OSL, OSR;

  always #5 clock = ~clock;

  ralu_sequencer dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .cmd_imm(cmd_imm), .cmd_fill(cmd_fill), .abort(abort), .done(done), .err(err),
    .busy(busy), .status(status), .DataIn(DataIn), .S(S), .M(M), .Pin(Pin),
    .ISR(ISR), .ISL(ISL), .A(A), .wr(wr), .adr(adr), .v(v),
    .Pout(Pout), .OSL(OSL), .OSR(OSR)
  );

  // ---------------- behavioural RALU ----------------
  logic [3:0] gprb [8] = '{default: 4'd0};
  logic [3:0] areg = 4'd0, breg = 4'd0;
  logic [4:0] sum;
  logic [3:0] wdata;
  logic       pout_m, osl_m;

  always_comb begin
    sum    = {1'b0, areg} + {1'b0, breg};
    wdata  = areg;
    if (S == S_ADD && M)       wdata = sum[3:0];
    else if (S == S_AND && !M) wdata = areg & breg;
    else if (S == S_SHL)       wdata = {breg[2:0], ISL};
    pout_m = (S == S_ADD && M) ? sum[4] : 1'b0;
    osl_m  = (v == V_SHB) ? breg[3] : 1'b0;
  end
  assign Pout = pout_m;
  assign OSL  = osl_m;
  assign OSR  = 1'b0;

  always @(posedge clock) begin
    if (wr) gprb[adr] <= wdata;
    if (v == V_LDA)      areg <= A ? DataIn : gprb[adr];
    else if (v == V_LDB) breg <= gprb[adr];
    else if (v == V_SHB) breg <= {breg[2:0], ISL};
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit is_err;
    int lat;
    bit st;
  } resp_t;

  resp_t       resp_q[$];
  logic [20:0] word_q[$];
  int          n_checks = 0, n_pass = 0;
  int          cyc = 0, acc_at = 0;
  logic [20:0] w_act, w_exp;
  resp_t       r;

  assign w_act = {DataIn, S, M, Pin, ISR, ISL, A, wr, adr, v};

  function automatic logic [20:0] mkw(input logic [3:0] d, input logic [3:0] s,
                                      input logic m, input logic fl, input logic a,
                                      input logic w, input logic [2:0] ad,
                                      input logic [3:0] vv);
    return {d, s, m, 1'b0, fl, fl, a, w, ad, vv};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic exp_resp(input bit is_err, input int lat, input bit st);
    resp_t e;
    e.is_err = is_err;
    e.lat    = lat;
    e.st     = st;
    resp_q.push_back(e);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: pops expected words/responses whenever the DUT shows one.
  always @(negedge clock) begin
    if (!reset) begin
      if (w_act != 21'd0) begin
        if (word_q.size() == 0) chk("unexpected_word", int'(w_act), 0);
        else begin
          w_exp = word_q.pop_front();
          chk("ctrl_word", int'(w_act), int'(w_exp));
        end
      end
      if (done || err) begin
        if (resp_q.size() == 0) chk("unexpected_resp", int'({done, err}), 0);
        else begin
          r = resp_q.pop_front();
          chk("resp_done", int'(done), int'(!r.is_err));
          chk("resp_err", int'(err), int'(r.is_err));
          chk("latency", cyc - acc_at + 1, r.lat);
          chk("status", int'(status), int'(r.st));
        end
      end
      if (cmd_valid && cmd_ready) acc_at = cyc + 1;
    end
  end

  // Drive a command (called at posedge+#1), return #1 after the accept edge.
  task automatic send(input logic [2:0] op, input logic [2:0] sa, input logic [2:0] sb,
                      input logic [2:0] d, input logic [3:0] imm, input logic fill);
    int k;
    k = 0;
    cmd_op = op; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = d;
    cmd_imm = imm; cmd_fill = fill; cmd_valid = 1'b1;
    do begin
      @(negedge clock);
      k++;
    end while (!cmd_ready && k < 60);
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((resp_q.size() != 0 || word_q.size() != 0) && k < 60) begin
      @(posedge clock);
      k++;
    end
    @(posedge clock);
    #1;
    if (k >= 60) chk("drain_timeout", k, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clock);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_word", int'(w_act), 0);
    chk("rst_done_err", int'({done, err}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_status", int'(status), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    // LDI 3 -> R0
    word_q.push_back(mkw(4'd3, 4'd0, 0, 0, 1, 0, 3'd0, V_LDA));
    word_q.push_back(mkw(4'd0, 4'd0, 0, 0, 0, 1, 3'd0, 4'd0));
    exp_resp(0, 3, 0);
    send(OP_LDI, 3'd0, 3'd0, 3'd0, 4'd3, 1'b0);
    wait_idle();
    chk("gprb0_ldi", int'(gprb[0]), 3);

    // LDI 12 -> R1
    word_q.push_back(mkw(4'd12, 4'd0, 0, 0, 1, 0, 3'd0, V_LDA));
    word_q.push_back(mkw(4'd0, 4'd0, 0, 0, 0, 1, 3'd1, 4'd0));
    exp_resp(0, 3, 0);
    send(OP_LDI, 3'd0, 3'd0, 3'd1, 4'd12, 1'b0);
    wait_idle();

    // ADD R0+R1 -> R1 : 3+12 = 15, carry 0
    word_q.push_back(mkw(4'd0, 4'd0, 0, 0, 0, 0, 3'd0, V_LDA));
    word_q.push_back(mkw(4'd0, 4'd0, 0, 0, 0, 0, 3'd1, V_LDB));
    word_q.push_back(mkw(4'd0, S_ADD, 1, 0, 0, 1, 3'd1, 4'd0));
    exp_resp(0, 4, 0);
    send(OP_ADD, 3'd0, 3'd1, 3'd1, 4'd0, 1'b0);
    wait_idle();
    chk("gprb1_add", int'(gprb[1]), 15);

    // SHL R0 by 3, fill 0 -> R0 : 0011 -> 1000, last OSL = 1
    word_q.push_back(mkw(4'd0, 4'd0, 0, 0, 0, 0, 3'd0, V_LDB));
    word_q.push_back(mkw(4'd0, S_SHL, 0, 0, 0, 0, 3'd0, V_SHB));
    word_q.push_back(mkw(4'd0, S_SHL, 0, 0, 0, 0, 3'd0, V_SHB));
    word_q.push_back(mkw(4'd0, S_SHL, 0, 0, 0, 1, 3'd0, V_SHB));
    exp_resp(0, 5, 1);
    send(OP_SHL, 3'd0, 3'd0, 3'd0, 4'd2, 1'b0);
    wait_idle();
    chk("gprb0_shl", int'(gprb[0]), 8);

    // SHL R1 by 1, fill 1 -> R2 : 1111 -> 1111, OSL = 1 (single-step boundary)
    word_q.push_back(mkw(4'd0, 4'd0, 0, 0, 0, 0, 3'd1, V_LDB));
    word_q.push_back(mkw(4'd0, S_SHL, 0, 1, 0, 1, 3'd2, V_SHB));
    exp_resp(0, 3, 1);
    send(OP_SHL, 3'd1, 3'd0, 3'd2, 4'd0, 1'b1);
    wait_idle();
    chk("gprb2_shl1", int'(gprb[2]), 15);

    // Illegal opcode: err after 1 cycle, status stays 1, no words
    exp_resp(1, 1, 1);
    send(3'd5, 3'd0, 3'd0, 3'd3, 4'd0, 1'b0);
    wait_idle();
    chk("gprb3_after_err", int'(gprb[3]), 0);

    // AND R0&R1 -> R3 : 8&15 = 8, status 0
    word_q.push_back(mkw(4'd0, 4'd0, 0, 0, 0, 0, 3'd0, V_LDA));
    word_q.push_back(mkw(4'd0, 4'd0, 0, 0, 0, 0, 3'd1, V_LDB));
    word_q.push_back(mkw(4'd0, S_AND, 0, 0, 0, 1, 3'd3, 4'd0));
    exp_resp(0, 4, 0);
    send(OP_AND, 3'd0, 3'd1, 3'd3, 4'd0, 1'b0);
    wait_idle();
    chk("gprb3_and", int'(gprb[3]), 8);

    // ADD R1+R2 -> R4 (15+15 = 14 carry 1), then LDI 5 -> R5 held during busy
    word_q.push_back(mkw(4'd0, 4'd0, 0, 0, 0, 0, 3'd1, V_LDA));
    word_q.push_back(mkw(4'd0, 4'd0, 0, 0, 0, 0, 3'd2, V_LDB));
    word_q.push_back(mkw(4'd0, S_ADD, 1, 0, 0, 1, 3'd4, 4'd0));
    exp_resp(0, 4, 1);
    send(OP_ADD, 3'd1, 3'd2, 3'd4, 4'd0, 1'b0);
    word_q.push_back(mkw(4'd5, 4'd0, 0, 0, 1, 0, 3'd0, V_LDA));
    word_q.push_back(mkw(4'd0, 4'd0, 0, 0, 0, 1, 3'd5, 4'd0));
    exp_resp(0, 3, 0);
    send(OP_LDI, 3'd0, 3'd0, 3'd5, 4'd5, 1'b0);
    wait_idle();
    chk("gprb4_carry_add", int'(gprb[4]), 14);
    chk("gprb5_held_ldi", int'(gprb[5]), 5);

    // ADD R0+R1 -> R0 aborted in LOADB: no done, R0 unchanged
    word_q.push_back(mkw(4'd0, 4'd0, 0, 0, 0, 0, 3'd0, V_LDA));
    word_q.push_back(mkw(4'd0, 4'd0, 0, 0, 0, 0, 3'd1, V_LDB));
    send(OP_ADD, 3'd0, 3'd1, 3'd0, 4'd0, 1'b0);
    @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    @(negedge clock);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_word", int'(w_act), 0);
    repeat (4) @(posedge clock);
    #1;
    wait_idle();
    chk("gprb0_after_abort", int'(gprb[0]), 8);

    // abort together with accept in IDLE: command is accepted normally
    word_q.push_back(mkw(4'd9, 4'd0, 0, 0, 1, 0, 3'd0, V_LDA));
    word_q.push_back(mkw(4'd0, 4'd0, 0, 0, 0, 1, 3'd6, 4'd0));
    exp_resp(0, 3, 0);
    abort = 1'b1;
    send(OP_LDI, 3'd0, 3'd0, 3'd6, 4'd9, 1'b0);
    abort = 1'b0;
    wait_idle();
    chk("gprb6_abort_accept", int'(gprb[6]), 9);

    // SHL by 4 into R7, async reset during first SHIFT step
    word_q.push_back(mkw(4'd0, 4'd0, 0, 0, 0, 0, 3'd1, V_LDB));
    word_q.push_back(mkw(4'd0, S_SHL, 0, 1, 0, 0, 3'd0, V_SHB));
    send(OP_SHL, 3'd1, 3'd0, 3'd7, 4'd3, 1'b1);
    @(posedge clock);
    #1;
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midrst_word", int'(w_act), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_status", int'(status), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("postrst_ready", int'(cmd_ready), 1);
    chk("postrst_word", int'(w_act), 0);
    @(posedge clock);
    #1;
    wait_idle();
    chk("gprb7_after_reset", int'(gprb[7]), 0);

    // Normal operation after reset
    word_q.push_back(mkw(4'd6, 4'd0, 0, 0, 1, 0, 3'd0, V_LDA));
    word_q.push_back(mkw(4'd0, 4'd0, 0, 0, 0, 1, 3'd7, 4'd0));
    exp_resp(0, 3, 0);
    send(OP_LDI, 3'd0, 3'd0, 3'd7, 4'd6, 1'b0);
    wait_idle();
    chk("gprb7_ldi", int'(gprb[7]), 6);

    repeat (3) @(posedge clock);
    #1;
    chk("resp_queue_empty", resp_q.size(), 0);
    chk("word_queue_empty", word_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
